// File: rtl/string_led_pkg.sv
// Shared timing constants and FSM encoding for the single-wire LED string link.
// Receiver and transmitter both import this so their pulse timing agrees.
package string_led_pkg;

  localparam int CNT_W            = 16;
  localparam int T1H_MIN_DEF      = 24;
  localparam int HIGH_MAX_DEF     = 64;
  localparam int RESET_CYCLES_DEF = 2000;
  localparam int NB_BITS_DEF      = 24;

  // Transmitter pulse shapes, in clk cycles
  localparam int TX_T0H    = 16;
  localparam int TX_T1H    = 32;
  localparam int TX_PERIOD = 50;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    FORWARD
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/string_led_receiver_edge_detect.sv
// Two-flop synchroniser for the asynchronous data wire, plus rise/fall strobes
// derived from the synchronised level.
module string_led_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign din_s = sync2;
  assign rise  = sync2 & ~prev;
  assign fall  = ~sync2 & prev;

endmodule

// File: rtl/string_led_receiver.sv
// Single-wire LED-string pixel receiver: captures the first pixel after a latch,
// then forwards the remaining stream downstream until the next reset code.
//
// state   | meaning
// IDLE    | waiting for first rising edge (or, after a pulse error, for a reset code)
// HIGH    | measuring a high pulse
// LOW     | between bits of the pixel being captured
// FORWARD | own pixel captured; repeating din_s on dout until a reset code
module string_led_receiver
  import string_led_pkg::*;
#(
  parameter int T1H_MIN      = T1H_MIN_DEF,
  parameter int HIGH_MAX     = HIGH_MAX_DEF,
  parameter int RESET_CYCLES = RESET_CYCLES_DEF,
  parameter int NB_BITS      = NB_BITS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  output logic               dout,
  output logic [NB_BITS-1:0] pixel_data,
  output logic               pixel_valid,
  output logic               latch,
  output logic               error
);

  localparam int BW = $clog2(NB_BITS + 1);

  logic din_s, rise, fall;

  string_led_edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall)
  );

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   high_cnt, high_nxt;
  logic [CNT_W-1:0]   low_cnt, low_inc;
  logic [BW-1:0]      bit_cnt, bit_nxt;
  logic [NB_BITS-1:0] shift, shift_nxt, pdata_nxt;
  logic               wait_rst, wait_nxt;
  logic               pv_nxt, latch_nxt, err_nxt, dout_nxt;
  logic               reset_code, bit_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      high_cnt    <= '0;
      low_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      wait_rst    <= 1'b0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      latch       <= 1'b0;
      error       <= 1'b0;
      dout        <= 1'b0;
    end else begin
      state       <= state_nxt;
      high_cnt    <= high_nxt;
      low_cnt     <= din_s ? '0 : low_inc;
      bit_cnt     <= bit_nxt;
      shift       <= shift_nxt;
      wait_rst    <= wait_nxt;
      pixel_data  <= pdata_nxt;
      pixel_valid <= pv_nxt;
      latch       <= latch_nxt;
      error       <= err_nxt;
      dout        <= dout_nxt;
    end
  end

  // Reset code fires on the RESET_CYCLES-th consecutive low cycle itself.
  assign low_inc    = sat_inc(low_cnt);
  assign reset_code = !din_s && (low_inc >= CNT_W'(RESET_CYCLES));
  assign bit_val    = (high_cnt >= CNT_W'(T1H_MIN));

  always_comb begin
    state_nxt = state;
    high_nxt  = high_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    wait_nxt  = wait_rst;
    pdata_nxt = pixel_data;
    pv_nxt    = 1'b0;
    latch_nxt = 1'b0;
    err_nxt   = 1'b0;
    dout_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (wait_rst) begin
          if (reset_code) begin
            latch_nxt = 1'b1;
            wait_nxt  = 1'b0;
          end
        end else if (rise) begin
          state_nxt = HIGH;
          high_nxt  = CNT_W'(1);
        end
      end
      HIGH: begin
        if (fall) begin
          shift_nxt = {shift[NB_BITS-2:0], bit_val};
          if (bit_cnt == BW'(NB_BITS - 1)) begin
            pdata_nxt = shift_nxt;
            pv_nxt    = 1'b1;
            bit_nxt   = '0;
            state_nxt = FORWARD;
          end else begin
            bit_nxt   = bit_cnt + BW'(1);
            state_nxt = LOW;
          end
        end else if (din_s) begin
          high_nxt = sat_inc(high_cnt);
          if (high_nxt > CNT_W'(HIGH_MAX)) begin
            err_nxt   = 1'b1;
            wait_nxt  = 1'b1;
            bit_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      LOW: begin
        // Only partial pixels live in LOW, so a reset code here is a truncation.
        if (reset_code) begin
          latch_nxt = 1'b1;
          err_nxt   = 1'b1;
          bit_nxt   = '0;
          state_nxt = IDLE;
        end else if (rise) begin
          state_nxt = HIGH;
          high_nxt  = CNT_W'(1);
        end
      end
      FORWARD: begin
        if (reset_code) begin
          latch_nxt = 1'b1;
          bit_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          dout_nxt = din_s;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_string_led_receiver.sv
// Directed bench for string_led_receiver: pixel capture, forwarding, latch,
// truncation and pulse-length errors, timing boundaries and mid-pixel reset.
module tb_string_led_receiver;
  import string_led_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        dout;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        latch;
  logic        error;

  int n_assert = 0;
  int n_fail   = 0;

  int   cyc = 0, pv_cnt = 0, latch_cnt = 0, err_cnt = 0;
  int   latch_cyc = 0, err_cyc = 0, dout_rise = 0, dout_bad = 0;
  logic dout_prev = 1'b0;
  logic [31:0] din_hist = '0;
  bit   fwd_chk = 1'b0;
  int   first_err;

  string_led_receiver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .dout        (dout),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .latch       (latch),
    .error       (error)
  );

  always #5 clk = ~clk;

  // Event monitor; dout must equal din from three cycles earlier while forwarding.
  always @(negedge clk) begin
    cyc++;
    if (pixel_valid === 1'b1) pv_cnt++;
    if (latch === 1'b1) begin latch_cnt++; latch_cyc = cyc; end
    if (error === 1'b1) begin err_cnt++; err_cyc = cyc; end
    if (dout === 1'b1 && dout_prev !== 1'b1) dout_rise++;
    dout_prev = dout;
    if (fwd_chk && dout !== din_hist[2]) dout_bad++;
    din_hist = {din_hist[30:0], din};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    din = 1'b1;
    tick(hi);
    din = 1'b0;
    tick(lo);
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse(TX_T1H, TX_PERIOD - TX_T1H);
    else   pulse(TX_T0H, TX_PERIOD - TX_T0H);
  endtask

  task automatic send_bits(input logic [23:0] v, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(v[i]);
  endtask

  task automatic rst_code();
    din = 1'b0;
    tick(RESET_CYCLES_DEF + 10);
  endtask

  task automatic clear_mon();
    pv_cnt = 0; latch_cnt = 0; err_cnt = 0;
    latch_cyc = 0; err_cyc = 0; dout_rise = 0; dout_bad = 0;
  endtask

  initial begin
    // Reset values
    tick(3);
    check("rst_dout", dout, 0);
    check("rst_pixel_data", pixel_data, 0);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_latch", latch, 0);
    check("rst_error", error, 0);
    rst_n = 1'b1;
    tick(2);

    // Single pixel 0xA5C33C with 3-edge capture latency on the last fall
    clear_mon();
    send_bits(24'hA5C33C, 23);
    din = 1'b1;
    tick(TX_T0H);
    din = 1'b0;
    tick(2);
    check("lat_pv_edge2", pixel_valid, 0);
    tick(1);
    check("lat_pv_edge3", pixel_valid, 1);
    check("p1_pixel_data", pixel_data, 24'hA5C33C);
    tick(1);
    check("lat_pv_pulse_len", pixel_valid, 0);
    rst_code();
    check("p1_pv_cnt", pv_cnt, 1);
    check("p1_latch_cnt", latch_cnt, 1);
    check("p1_dout_quiet", dout_rise, 0);
    check("p1_err_cnt", err_cnt, 0);

    // Three pixels: first captured, next two forwarded
    clear_mon();
    send_bits(24'h112233, 24);
    fwd_chk = 1'b1;
    send_bits(24'h445566, 24);
    send_bits(24'h778899, 24);
    rst_code();
    fwd_chk = 1'b0;
    check("p3_pixel_data", pixel_data, 24'h112233);
    check("p3_pv_cnt", pv_cnt, 1);
    check("p3_latch_cnt", latch_cnt, 1);
    check("p3_dout_rises", dout_rise, 48);
    check("p3_dout_delay", dout_bad, 0);
    check("p3_err_cnt", err_cnt, 0);

    // Truncated pixel (10 bits) then a good pixel
    clear_mon();
    send_bits(24'hABCDEF, 10);
    rst_code();
    check("tr_latch_cnt", latch_cnt, 1);
    check("tr_err_cnt", err_cnt, 1);
    check("tr_err_with_latch", err_cyc, latch_cyc);
    check("tr_pv_cnt", pv_cnt, 0);
    check("tr_pixel_kept", pixel_data, 24'h112233);
    send_bits(24'h0000FF, 24);
    rst_code();
    check("tr_next_pixel", pixel_data, 24'h0000FF);
    check("tr_next_pv_cnt", pv_cnt, 1);
    check("tr_next_latch_cnt", latch_cnt, 2);

    // Over-long high pulse: error when count passes HIGH_MAX, then wait for reset code
    clear_mon();
    first_err = -1;
    din = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick(1);
      if (error === 1'b1 && first_err < 0) first_err = k;
    end
    din = 1'b0;
    check("he_err_edge", first_err, 67);
    tick(100);
    send_bits(24'h123456, 24);
    check("he_ignored_pv", pv_cnt, 0);
    check("he_no_latch_yet", latch_cnt, 0);
    check("he_err_once", err_cnt, 1);
    rst_code();
    check("he_wait_latch", latch_cnt, 1);
    send_bits(24'h654321, 24);
    rst_code();
    check("he_next_pixel", pixel_data, 24'h654321);
    check("he_next_pv_cnt", pv_cnt, 1);
    check("he_err_total", err_cnt, 1);

    // Boundaries: high 23 -> 0, high 24 -> 1; low 1999 no latch, 2000 latch
    clear_mon();
    pulse(23, 27);
    pulse(24, 26);
    send_bits(24'h000000, 21);
    pulse(TX_T0H, 1999);
    check("bd_pixel_data", pixel_data, 24'h400000);
    check("bd_pv_cnt", pv_cnt, 1);
    check("bd_low1999_latch", latch_cnt, 0);
    pulse(TX_T0H, 2000);
    tick(1);
    check("bd_low2000_early", latch, 0);
    tick(1);
    check("bd_low2000_latch", latch, 1);
    tick(5);
    check("bd_latch_cnt", latch_cnt, 1);
    check("bd_fwd_rises", dout_rise, 1);
    check("bd_err_cnt", err_cnt, 0);

    // Asynchronous reset in the middle of a pixel
    clear_mon();
    send_bits(24'h5A5A5A, 12);
    rst_n = 1'b0;
    #1;
    check("mr_pixel_data", pixel_data, 0);
    check("mr_dout", dout, 0);
    check("mr_pixel_valid", pixel_valid, 0);
    check("mr_latch", latch, 0);
    check("mr_error", error, 0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("mr_no_err", err_cnt, 0);
    send_bits(24'hFFFFFF, 24);
    tick(5);
    check("mr_pixel", pixel_data, 24'hFFFFFF);
    check("mr_pv_cnt", pv_cnt, 1);
    rst_code();
    check("mr_latch_cnt", latch_cnt, 1);
    check("mr_err_cnt", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
